dt2_id_stage_param: RTL and testbench
=====================================

Name: dt2_id_stage_param

Overview:
Parametrised next-generation decode stage for the RV32 pipeline. It contains:
- a register file with NUM_REGS entries, XLEN bits wide, with W-to-D write-through bypass;
- an immediate extender;
- an ID/EX pipeline register with a valid bit, stall/flush priority and built-in load-use bubble insertion.
The control decoder stays outside this block; its control word enters as an opaque CTRL_W-bit vector.

Parameters:
XLEN, 32, datapath width for register data, PC and immediates (immediates sign-extend to XLEN).
NUM_REGS, 32, architectural register count, 32 or 16 (RV32E); address width is fixed at 5.
CTRL_W, 20, width of the opaque control word passed D to E.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
InstrD  in  32  instruction in decode
PCD  in  XLEN  PC of InstrD
PCPlus4D  in  XLEN  PC+4 of InstrD
ValidD  in  1  InstrD is a real instruction
CtrlD  in  CTRL_W  control word from decoder
MemReadD  in  1  InstrD is a load
ImmSrcD  in  3  immediate format select
StallE  in  1  hold ID/EX register
FlushE  in  1  clear ID/EX register
RegWriteW  in  1  writeback enable
RdW  in  5  writeback destination
ResultW  in  XLEN  writeback data
LoadUseStallD  out  1  combinational; upstream must hold F/D
RD1E, RD2E  out  XLEN  register operands
PCE, PCPlus4E, ImmExtE  out  XLEN  registered PC, PC+4, immediate
Rs1E, Rs2E, RdE  out  5  register indices
CtrlE  out  CTRL_W  registered control word
MemReadE  out  1  registered load flag
ValidE  out  1  E holds a real instruction
IllegalRegE  out  1  instruction referenced a register index >= NUM_REGS

Behaviour:
- Regfile:
  - rst clears all entries to 0.
  - Write on posedge when RegWriteW && RdW!=0 && RdW<NUM_REGS.
  - x0 always reads 0.
- Read bypass: if RegWriteW && RdW!=0 && RdW==InstrD[19:15], RD1D=ResultW (same rule for rs2 / InstrD[24:20]). Read latency is zero.
- Indices >= NUM_REGS read as 0 and are never written.
- Immediate (ImmSrcD):
  - 000: I (sign-ext [31:20]).
  - 001: S.
  - 010: B (bit0=0).
  - 011: J (bit0=0).
  - 100: shamt, zero-ext [24:20].
  - 101: U ([31:12]<<12).
  - 110/111: 0. Never X.
- Load-use:
  - LoadUseStallD = ValidE && MemReadE && RdE!=0 && ValidD && (RdE==InstrD[19:15] || RdE==InstrD[24:20]).
  - It is purely combinational from E-register state and InstrD.
- IllegalReg (internal, D side): when NUM_REGS==16 and ValidD and any of InstrD[19], InstrD[24] or InstrD[11] is 1. It is always 0 for NUM_REGS==32. It is registered into IllegalRegE.
- ID/EX register update, posedge, priority highest first:
  1. rst: every output register = 0 (ValidE=0, CtrlE=0, all data 0).
  2. FlushE: all cleared as for rst. FlushE wins over StallE.
  3. StallE: all held. LoadUseStallD is still evaluated from held E contents.
  4. LoadUseStallD: bubble inserted. ValidE=0, CtrlE=0, MemReadE=0, IllegalRegE=0; data fields are don't-care but driven to 0.
  5. Otherwise: load D values. ValidE=ValidD. When ValidD=0, CtrlE and MemReadE are forced to 0.
- Latency: D to E is one cycle.
- Back-to-back load-use: exactly one bubble, because after the bubble ValidE=0 and LoadUseStallD drops.
- rst asserted mid-stall or mid-bubble: rst overrides, and the next cycle starts clean.

Optional Feature:
- Macro: RVFI_EN.
- When defined, the block adds:
  - output rvfi_valid_e (=ValidE);
  - output rvfi_insn_e (32, registered InstrD);
  - output rvfi_order_e (64).
- rvfi_order_e counter:
  - Cleared on rst.
  - Increments by 1 on each cycle the register loads an instruction with ValidD=1 (priority case 5).
  - rvfi_order_e is the pre-increment value captured with that instruction.
  - Flush, stall and bubble neither increment nor change it.
- When undefined: these ports and the counter do not exist, and the remaining behaviour is identical.

Test Plan:
1. Reset, then write x5=0x1234 (RegWriteW=1, RdW=5), and the same cycle decode add with rs1=5. Next cycle: RD1E=0x1234 (bypass). A write to x0 leaves x0 reading 0.
2. ImmSrcD sweep with InstrD=0xFFF00093: I gives ImmExtE=0xFFFFFFFF. With 100 on InstrD=0x01F01013: ImmExtE=0x1F. With 110: 0.
3. Load to x7 in E, followed by add x8,x7,x1 with ValidD=1:
   - LoadUseStallD=1 for exactly one cycle.
   - Next cycle: ValidE=0, CtrlE=0.
   - Following cycle: the add appears with ValidE=1.
4. StallE=1 and FlushE=1 together: all E outputs go to 0. StallE alone for 3 cycles: E outputs unchanged.
5. NUM_REGS=16, InstrD with rs2=17, ValidD=1: next cycle IllegalRegE=1 and RD2E=0. Writes with RdW=20 do not change any readable register.
6. With RVFI_EN: 3 valid instructions with one flush between them give rvfi_order_e values 0, 1, 2, and the flush does not increment the counter.

Source files
------------

// File: rtl/dt2_id_stage_param_if.sv
// Decode-to-execute bus for dt2_id_stage_param: D-side inputs, writeback port, E-side outputs.
// Optional RVFI_EN adds the rvfi_* trace signals.
interface dt2_id_stage_param_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 20
);
  logic [31:0]       InstrD;
  logic [XLEN-1:0]   PCD;
  logic [XLEN-1:0]   PCPlus4D;
  logic              ValidD;
  logic [CTRL_W-1:0] CtrlD;
  logic              MemReadD;
  logic [2:0]        ImmSrcD;
  logic              StallE;
  logic              FlushE;
  logic              RegWriteW;
  logic [4:0]        RdW;
  logic [XLEN-1:0]   ResultW;

  logic              LoadUseStallD;
  logic [XLEN-1:0]   RD1E;
  logic [XLEN-1:0]   RD2E;
  logic [XLEN-1:0]   PCE;
  logic [XLEN-1:0]   PCPlus4E;
  logic [XLEN-1:0]   ImmExtE;
  logic [4:0]        Rs1E;
  logic [4:0]        Rs2E;
  logic [4:0]        RdE;
  logic [CTRL_W-1:0] CtrlE;
  logic              MemReadE;
  logic              ValidE;
  logic              IllegalRegE;
`ifdef RVFI_EN
  logic              rvfi_valid_e;
  logic [31:0]       rvfi_insn_e;
  logic [63:0]       rvfi_order_e;
`endif

  modport master (
    output InstrD, PCD, PCPlus4D, ValidD, CtrlD, MemReadD, ImmSrcD,
           StallE, FlushE, RegWriteW, RdW, ResultW,
    input  LoadUseStallD, RD1E, RD2E, PCE, PCPlus4E, ImmExtE,
           Rs1E, Rs2E, RdE, CtrlE, MemReadE, ValidE, IllegalRegE
`ifdef RVFI_EN
    , input rvfi_valid_e, rvfi_insn_e, rvfi_order_e
`endif
  );

  modport slave (
    input  InstrD, PCD, PCPlus4D, ValidD, CtrlD, MemReadD, ImmSrcD,
           StallE, FlushE, RegWriteW, RdW, ResultW,
    output LoadUseStallD, RD1E, RD2E, PCE, PCPlus4E, ImmExtE,
           Rs1E, Rs2E, RdE, CtrlE, MemReadE, ValidE, IllegalRegE
`ifdef RVFI_EN
    , output rvfi_valid_e, rvfi_insn_e, rvfi_order_e
`endif
  );
endinterface

// File: rtl/dt2_id_stage_param.sv
// RV32 decode stage: bypassing regfile, immediate extender, ID/EX register with load-use bubble.
// Define RVFI_EN to add the rvfi_valid_e / rvfi_insn_e / rvfi_order_e trace outputs.
module dt2_id_stage_param #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int CTRL_W   = 20
) (
  input logic                 clk,
  input logic                 rst,
  dt2_id_stage_param_if.slave bus
);
  localparam int         AW  = (NUM_REGS == 16) ? 4 : 5;
  localparam logic [5:0] NR6 = 6'(NUM_REGS);

  logic [31:0] w_ins;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic        w_unused_opcode;

  assign w_ins           = bus.InstrD;
  assign w_rs1           = w_ins[19:15];
  assign w_rs2           = w_ins[24:20];
  assign w_rd            = w_ins[11:7];
  assign w_unused_opcode = ^w_ins[6:0];

  // Entry 0 has no storage; entries only match their own index so out-of-range RdW never writes.
  logic [XLEN-1:0] w_rf [NUM_REGS];
  assign w_rf[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_rf
      logic [XLEN-1:0] r_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_q <= '0;
        end else if (bus.RegWriteW && (bus.RdW == 5'(gi))) begin
          r_q <= bus.ResultW;
        end
      end
      assign w_rf[gi] = r_q;
    end
  endgenerate

  logic [4:0]      w_raddr [2];
  logic [XLEN-1:0] w_rdata [2];
  assign w_raddr[0] = w_rs1;
  assign w_raddr[1] = w_rs2;

  // Out-of-range indices read 0 even if the writeback port targets the same index.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rport
      logic w_in_range;
      logic w_bypass;
      assign w_in_range = ({1'b0, w_raddr[gi]} < NR6) && (w_raddr[gi] != 5'd0);
      assign w_bypass   = bus.RegWriteW && (bus.RdW == w_raddr[gi]);
      assign w_rdata[gi] = !w_in_range ? '0 :
                           w_bypass    ? bus.ResultW :
                                         w_rf[w_raddr[gi][AW-1:0]];
    end
  endgenerate

  logic [XLEN-1:0] w_imm;
  always_comb begin
    w_imm = '0;
    case (bus.ImmSrcD)
      3'b000: w_imm = XLEN'($signed(w_ins[31:20]));
      3'b001: w_imm = XLEN'($signed({w_ins[31:25], w_ins[11:7]}));
      3'b010: w_imm = XLEN'($signed({w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0}));
      3'b011: w_imm = XLEN'($signed({w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0}));
      3'b100: w_imm = XLEN'(w_ins[24:20]);
      3'b101: w_imm = XLEN'($signed({w_ins[31:12], 12'h000}));
      default: w_imm = '0;
    endcase
  end

  // Bit 4 of any index set means x16..x31, which RV32E does not have.
  logic w_illegal;
  assign w_illegal = (NUM_REGS == 16) && bus.ValidD && (w_ins[19] || w_ins[24] || w_ins[11]);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_memread;
  logic              r_illegal;
  logic [XLEN-1:0]   r_rd1;
  logic [XLEN-1:0]   r_rd2;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_pc4;
  logic [XLEN-1:0]   r_imm;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [4:0]        r_rd;

  logic w_load_use;
  logic w_clear;
  logic w_load;

  assign w_load_use = r_valid && r_memread && (r_rd != 5'd0) && bus.ValidD &&
                      ((r_rd == w_rs1) || (r_rd == w_rs2));

  // Stall only shields the bubble, never a flush or reset.
  assign w_clear = rst || bus.FlushE || (!bus.StallE && w_load_use);
  assign w_load  = !rst && !bus.FlushE && !bus.StallE && !w_load_use;

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_valid   <= 1'b0;
      r_ctrl    <= '0;
      r_memread <= 1'b0;
      r_illegal <= 1'b0;
      r_rd1     <= '0;
      r_rd2     <= '0;
      r_pc      <= '0;
      r_pc4     <= '0;
      r_imm     <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
    end else if (w_load) begin
      r_valid   <= bus.ValidD;
      r_ctrl    <= bus.ValidD ? bus.CtrlD : '0;
      r_memread <= bus.ValidD && bus.MemReadD;
      r_illegal <= w_illegal;
      r_rd1     <= w_rdata[0];
      r_rd2     <= w_rdata[1];
      r_pc      <= bus.PCD;
      r_pc4     <= bus.PCPlus4D;
      r_imm     <= w_imm;
      r_rs1     <= w_rs1;
      r_rs2     <= w_rs2;
      r_rd      <= w_rd;
    end
  end

  assign bus.LoadUseStallD = w_load_use;
  assign bus.ValidE        = r_valid;
  assign bus.CtrlE         = r_ctrl;
  assign bus.MemReadE      = r_memread;
  assign bus.IllegalRegE   = r_illegal;
  assign bus.RD1E          = r_rd1;
  assign bus.RD2E          = r_rd2;
  assign bus.PCE           = r_pc;
  assign bus.PCPlus4E      = r_pc4;
  assign bus.ImmExtE       = r_imm;
  assign bus.Rs1E          = r_rs1;
  assign bus.Rs2E          = r_rs2;
  assign bus.RdE           = r_rd;

`ifdef RVFI_EN
  logic [63:0] r_order;
  logic [63:0] r_rvfi_order;
  logic [31:0] r_rvfi_insn;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_order <= '0;
    end else if (w_load && bus.ValidD) begin
      r_order <= r_order + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_rvfi_order <= '0;
      r_rvfi_insn  <= '0;
    end else if (w_load) begin
      r_rvfi_order <= r_order;
      r_rvfi_insn  <= w_ins;
    end
  end

  assign bus.rvfi_valid_e = r_valid;
  assign bus.rvfi_insn_e  = r_rvfi_insn;
  assign bus.rvfi_order_e = r_rvfi_order;
`endif

endmodule

// File: tb/tb_dt2_id_stage_param.sv
// Random + directed bench for dt2_id_stage_param; runs a 32-entry and a 16-entry (RV32E) instance
// side by side against a behavioural model of the decode rules.
module tb_dt2_id_stage_param;
  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        vd;
  logic [19:0] ctrl;
  logic        mr;
  logic [2:0]  imms;
  logic        stall;
  logic        flush;
  logic        rw;
  logic [4:0]  rdw;
  logic [31:0] res;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dt2_id_stage_param_if #(.XLEN(32), .CTRL_W(20)) u_if32 ();
  dt2_id_stage_param_if #(.XLEN(32), .CTRL_W(20)) u_if16 ();

  assign u_if32.InstrD = instr;    assign u_if16.InstrD = instr;
  assign u_if32.PCD = pc;          assign u_if16.PCD = pc;
  assign u_if32.PCPlus4D = pc4;    assign u_if16.PCPlus4D = pc4;
  assign u_if32.ValidD = vd;       assign u_if16.ValidD = vd;
  assign u_if32.CtrlD = ctrl;      assign u_if16.CtrlD = ctrl;
  assign u_if32.MemReadD = mr;     assign u_if16.MemReadD = mr;
  assign u_if32.ImmSrcD = imms;    assign u_if16.ImmSrcD = imms;
  assign u_if32.StallE = stall;    assign u_if16.StallE = stall;
  assign u_if32.FlushE = flush;    assign u_if16.FlushE = flush;
  assign u_if32.RegWriteW = rw;    assign u_if16.RegWriteW = rw;
  assign u_if32.RdW = rdw;         assign u_if16.RdW = rdw;
  assign u_if32.ResultW = res;     assign u_if16.ResultW = res;

  dt2_id_stage_param #(.XLEN(32), .NUM_REGS(32), .CTRL_W(20)) u_dut32 (
    .clk(clk), .rst(rst), .bus(u_if32));
  dt2_id_stage_param #(.XLEN(32), .NUM_REGS(16), .CTRL_W(20)) u_dut16 (
    .clk(clk), .rst(rst), .bus(u_if16));

  typedef struct packed {
    logic        valid;
    logic [19:0] ctrl;
    logic        memread;
    logic        illegal;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] insn;
    logic [63:0] order;
    logic        rvfi_valid;
  } e_t;

  bit [31:0] m_rf [2][32];
  e_t        m_e [2];
  bit [63:0] m_order [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int nregs(input int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic bit [31:0] mdl_read(input int k, input bit [4:0] idx);
    if (idx == 0 || int'(idx) >= nregs(k)) return 32'h0;
    if (rw && rdw == idx) return res;
    return m_rf[k][idx];
  endfunction

  // Immediates rebuilt with arithmetic shifts and masks.
  function automatic bit [31:0] mdl_imm(input bit [31:0] in, input bit [2:0] s);
    int sv;
    bit [31:0] v;
    sv = int'(in);
    case (s)
      3'd0: v = 32'(sv >>> 20);
      3'd1: v = 32'((sv >>> 25) << 5) | 32'(in[11:7]);
      3'd2: v = 32'((sv >>> 31) << 12) | (32'(in[7]) << 11) | (32'(in[30:25]) << 5) | (32'(in[11:8]) << 1);
      3'd3: v = 32'((sv >>> 31) << 20) | (32'(in[19:12]) << 12) | (32'(in[20]) << 11) | (32'(in[30:21]) << 1);
      3'd4: v = (in >> 20) & 32'h1F;
      3'd5: v = in & 32'hFFFF_F000;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  function automatic e_t get_e(input int k);
    e_t g;
    g = '0;
    if (k == 0) begin
      g.valid = u_if32.ValidE; g.ctrl = u_if32.CtrlE; g.memread = u_if32.MemReadE;
      g.illegal = u_if32.IllegalRegE; g.rd1 = u_if32.RD1E; g.rd2 = u_if32.RD2E;
      g.pc = u_if32.PCE; g.pc4 = u_if32.PCPlus4E; g.imm = u_if32.ImmExtE;
      g.rs1 = u_if32.Rs1E; g.rs2 = u_if32.Rs2E; g.rd = u_if32.RdE;
`ifdef RVFI_EN
      g.insn = u_if32.rvfi_insn_e; g.order = u_if32.rvfi_order_e; g.rvfi_valid = u_if32.rvfi_valid_e;
`endif
    end else begin
      g.valid = u_if16.ValidE; g.ctrl = u_if16.CtrlE; g.memread = u_if16.MemReadE;
      g.illegal = u_if16.IllegalRegE; g.rd1 = u_if16.RD1E; g.rd2 = u_if16.RD2E;
      g.pc = u_if16.PCE; g.pc4 = u_if16.PCPlus4E; g.imm = u_if16.ImmExtE;
      g.rs1 = u_if16.Rs1E; g.rs2 = u_if16.Rs2E; g.rd = u_if16.RdE;
`ifdef RVFI_EN
      g.insn = u_if16.rvfi_insn_e; g.order = u_if16.rvfi_order_e; g.rvfi_valid = u_if16.rvfi_valid_e;
`endif
    end
    return g;
  endfunction

  task automatic cmp_e(input int k, input e_t got);
    e_t    exp;
    string s;
    exp = m_e[k];
    s = (k == 0) ? "32" : "16";
    chk({"ValidE", s}, got.valid, exp.valid);
    chk({"CtrlE", s}, got.ctrl, exp.ctrl);
    chk({"MemReadE", s}, got.memread, exp.memread);
    chk({"IllegalRegE", s}, got.illegal, exp.illegal);
    chk({"RD1E", s}, got.rd1, exp.rd1);
    chk({"RD2E", s}, got.rd2, exp.rd2);
    chk({"PCE", s}, got.pc, exp.pc);
    chk({"PCPlus4E", s}, got.pc4, exp.pc4);
    chk({"ImmExtE", s}, got.imm, exp.imm);
    chk({"Rs1E", s}, got.rs1, exp.rs1);
    chk({"Rs2E", s}, got.rs2, exp.rs2);
    chk({"RdE", s}, got.rd, exp.rd);
`ifdef RVFI_EN
    chk({"rvfi_valid", s}, got.rvfi_valid, exp.valid);
    if (exp.valid) begin
      chk({"rvfi_insn", s}, got.insn, exp.insn);
      chk({"rvfi_order", s}, got.order, exp.order);
    end
`endif
  endtask

  // Called at a negedge with the D inputs already set; returns at the next negedge.
  task automatic step();
    bit   lu [2];
    e_t   nxt;
    #2;
    for (int k = 0; k < 2; k++) begin
      lu[k] = m_e[k].valid && m_e[k].memread && m_e[k].rd != 0 && vd &&
              (m_e[k].rd == instr[19:15] || m_e[k].rd == instr[24:20]);
    end
    if (!rst) begin
      chk("LoadUse32", u_if32.LoadUseStallD, lu[0]);
      chk("LoadUse16", u_if16.LoadUseStallD, lu[1]);
    end
    for (int k = 0; k < 2; k++) begin
      nxt = m_e[k];
      if (rst || flush) begin
        nxt = '0;
      end else if (!stall) begin
        if (lu[k]) begin
          nxt = '0;
        end else begin
          nxt.valid   = vd;
          nxt.ctrl    = vd ? ctrl : 20'h0;
          nxt.memread = vd && mr;
          nxt.illegal = vd && nregs(k) == 16 &&
                        (instr[19:15] >= 16 || instr[24:20] >= 16 || instr[11:7] >= 16);
          nxt.rd1 = mdl_read(k, instr[19:15]);
          nxt.rd2 = mdl_read(k, instr[24:20]);
          nxt.pc  = pc;
          nxt.pc4 = pc4;
          nxt.imm = mdl_imm(instr, imms);
          nxt.rs1 = instr[19:15];
          nxt.rs2 = instr[24:20];
          nxt.rd  = instr[11:7];
          nxt.insn  = instr;
          nxt.order = m_order[k];
          nxt.rvfi_valid = vd;
          if (vd) m_order[k] = m_order[k] + 1;
        end
      end
      m_e[k] = nxt;
      if (rst) begin
        m_order[k] = 0;
        for (int r = 0; r < 32; r++) m_rf[k][r] = 0;
      end else if (rw && rdw != 0 && int'(rdw) < nregs(k)) begin
        m_rf[k][rdw] = res;
      end
    end
    @(posedge clk);
    #1;
    cmp_e(0, get_e(0));
    cmp_e(1, get_e(1));
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; instr = 32'h0000_0013; pc = 0; pc4 = 4; vd = 0; ctrl = 0; mr = 0;
    imms = 0; stall = 0; flush = 0; rw = 0; rdw = 0; res = 0;
  endtask

  function automatic bit [4:0] pick_reg();
    if ($urandom_range(0, 9) < 8) return 5'($urandom_range(0, 8));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    idle();
    rst = 1;
    @(negedge clk);
    step();
    step();
    chk("rst_ValidE", u_if32.ValidE, 0);
    chk("rst_CtrlE", u_if32.CtrlE, 0);

    // Write x5 and read it through the bypass in the same cycle.
    idle();
    rw = 1; rdw = 5; res = 32'h1234; vd = 1; ctrl = 20'h3;
    instr = {7'h0, 5'd0, 5'd5, 3'b000, 5'd3, 7'h33};
    step();
    chk("tp1_bypass", u_if32.RD1E, 32'h1234);
    rw = 1; rdw = 0; res = 32'hFFFF;
    instr = {7'h0, 5'd5, 5'd0, 3'b000, 5'd3, 7'h33};
    step();
    chk("tp1_x0", u_if32.RD1E, 0);
    chk("tp1_x5_stored", u_if32.RD2E, 32'h1234);

    idle();
    vd = 1; instr = 32'hFFF0_0093; imms = 3'b000;
    step();
    chk("tp2_I", u_if32.ImmExtE, 32'hFFFF_FFFF);
    instr = 32'h01F0_1013; imms = 3'b100;
    step();
    chk("tp2_shamt", u_if32.ImmExtE, 32'h1F);
    imms = 3'b110;
    step();
    chk("tp2_zero", u_if32.ImmExtE, 0);

    // Load x7 then a dependent add: exactly one bubble.
    idle();
    vd = 1; mr = 1; ctrl = 20'h5; instr = 32'h0001_2383;
    step();
    mr = 0; ctrl = 20'h7; instr = 32'h0013_8433;
    #1 chk("tp3_lu_hi", u_if32.LoadUseStallD, 1);
    step();
    chk("tp3_bubble_valid", u_if32.ValidE, 0);
    chk("tp3_bubble_ctrl", u_if32.CtrlE, 0);
    #1 chk("tp3_lu_lo", u_if32.LoadUseStallD, 0);
    step();
    chk("tp3_add_valid", u_if32.ValidE, 1);
    chk("tp3_add_rd", u_if32.RdE, 8);

    stall = 1; flush = 1;
    step();
    chk("tp4_flush_valid", u_if32.ValidE, 0);
    chk("tp4_flush_pc", u_if32.PCE, 0);
    idle();
    vd = 1; pc = 32'h100; pc4 = 32'h104; instr = 32'h0020_8093;
    step();
    for (int i = 0; i < 3; i++) begin
      stall = 1; pc = $urandom; instr = $urandom; vd = 1;
      step();
      chk("tp4_stall_pc", u_if32.PCE, 32'h100);
    end

    // RV32E: rs2 = x17 is illegal and reads 0; a write to x20 is ignored even as bypass.
    idle();
    vd = 1; instr = {7'h0, 5'd17, 5'd1, 3'b000, 5'd2, 7'h33};
    step();
    chk("tp5_illegal16", u_if16.IllegalRegE, 1);
    chk("tp5_rd2_16", u_if16.RD2E, 0);
    chk("tp5_illegal32", u_if32.IllegalRegE, 0);
    rw = 1; rdw = 20; res = 32'hABCD; instr = {7'h0, 5'd2, 5'd20, 3'b000, 5'd2, 7'h33};
    step();
    chk("tp5_rd1_16", u_if16.RD1E, 0);
    chk("tp5_rd1_32", u_if32.RD1E, 32'hABCD);

    // Three valid instructions around a flush.
    idle();
    rst = 1;
    step();
    idle();
    vd = 1; instr = 32'h0000_0113;
    step();
`ifdef RVFI_EN
    chk("tp6_order0", u_if32.rvfi_order_e, 0);
`endif
    flush = 1;
    step();
    flush = 0; instr = 32'h0000_0193;
    step();
`ifdef RVFI_EN
    chk("tp6_order1", u_if32.rvfi_order_e, 1);
`endif
    instr = 32'h0000_0213;
    step();
`ifdef RVFI_EN
    chk("tp6_order2", u_if32.rvfi_order_e, 2);
`endif

    for (int i = 0; i < 800; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 15) == 0);
      stall = ($urandom_range(0, 5) == 0);
      vd    = ($urandom_range(0, 99) < 85);
      mr    = ($urandom_range(0, 2) == 0);
      ctrl  = 20'($urandom);
      imms  = 3'($urandom_range(0, 7));
      pc    = $urandom;
      pc4   = pc + 4;
      instr = $urandom;
      instr[19:15] = pick_reg();
      instr[24:20] = pick_reg();
      instr[11:7]  = pick_reg();
      rw    = ($urandom_range(0, 1) == 1);
      rdw   = pick_reg();
      res   = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
